// File: rtl/mcpu_ctrl_fsm_pkg.sv
// Shared types and encodings for the MCPU multicycle controller:
// states, opcode/funct constants, ALUOp codes and access sizes.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_JR, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [2:0] {
        C_ILL, C_R, C_JR, C_I, C_LOAD, C_STORE, C_BRANCH, C_JUMP
    } iclass_e;

    typedef enum logic [1:0] {LS_BYTE = 2'd0, LS_HALF = 2'd1, LS_WORD = 2'd2} lsop_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
    localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

    localparam logic [3:0] ALU_ADD   = 4'h0, ALU_SUB   = 4'h1, ALU_FUNCT = 4'h2, ALU_ANDI  = 4'h3;
    localparam logic [3:0] ALU_ORI   = 4'h4, ALU_XORI  = 4'h5, ALU_LUI   = 4'h6, ALU_SLTI  = 4'h7;
    localparam logic [3:0] ALU_SLTIU = 4'h8, ALU_ADDI  = 4'h9, ALU_ADDIU = 4'hA, ALU_BNE   = 4'hB;
    localparam logic [3:0] ALU_BGTZ  = 4'hC, ALU_BLEZ  = 4'hD, ALU_BLTZ  = 4'hE, ALU_BGEZ  = 4'hF;

    typedef struct packed {
        iclass_e    cls;
        logic [3:0] aluop;
        lsop_e      lsop;
        logic       dmext;
        logic       link;
        logic       extop;
    } dec_t;

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface mcpu_ctrl_fsm_if #(parameter int ALUOP_W = 4) ();
    logic [5:0]         op, funct;
    logic [4:0]         rt;
    logic               mem_ready, mem_req;
    logic               IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, IorD, extop, dmEXTop;
    logic [1:0]         MemtoReg, PCSource, ALUSrcA, ALUSrcB, RegDst, lsop;
    logic [ALUOP_W-1:0] ALUOp;
    logic               illegal;
    logic [3:0]         state_o;

    modport master (
        input  op, funct, rt, mem_ready,
        output mem_req, IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, IorD, extop, dmEXTop,
        output MemtoReg, PCSource, ALUSrcA, ALUSrcB, RegDst, lsop, ALUOp, illegal, state_o
    );
    modport slave (
        output op, funct, rt, mem_ready,
        input  mem_req, IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, IorD, extop, dmEXTop,
        input  MemtoReg, PCSource, ALUSrcA, ALUSrcB, RegDst, lsop, ALUOp, illegal, state_o
    );
endinterface

// File: rtl/mcpu_ctrl_decode.sv
// Combinational instruction decode: op/funct/rt -> class, ALUOp code, access size.
module mcpu_ctrl_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output dec_t       dec
);
    always_comb begin
        dec.cls   = C_ILL;
        dec.aluop = ALU_ADD;
        dec.lsop  = LS_BYTE;
        dec.dmext = 1'b0;
        dec.link  = 1'b0;
        dec.extop = 1'b0;
        case (op)
            OP_RTYPE: begin
                dec.cls  = (funct == FN_JR || funct == FN_JALR) ? C_JR : C_R;
                dec.link = (funct == FN_JALR);
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: dec.cls = C_LOAD;
            OP_SB, OP_SH, OP_SW:                 dec.cls = C_STORE;
            OP_ADDI:  begin dec.cls = C_I; dec.aluop = ALU_ADDI; end
            OP_ADDIU: begin dec.cls = C_I; dec.aluop = ALU_ADDIU; dec.extop = 1'b1; end
            OP_SLTI:  begin dec.cls = C_I; dec.aluop = ALU_SLTI; end
            OP_SLTIU: begin dec.cls = C_I; dec.aluop = ALU_SLTIU; end
            OP_ANDI:  begin dec.cls = C_I; dec.aluop = ALU_ANDI; end
            OP_ORI:   begin dec.cls = C_I; dec.aluop = ALU_ORI; end
            OP_XORI:  begin dec.cls = C_I; dec.aluop = ALU_XORI; end
            OP_LUI:   begin dec.cls = C_I; dec.aluop = ALU_LUI; end
            OP_BEQ:   begin dec.cls = C_BRANCH; dec.aluop = ALU_SUB; end
            OP_BNE:   begin dec.cls = C_BRANCH; dec.aluop = ALU_BNE; end
            OP_BGTZ:  begin dec.cls = C_BRANCH; dec.aluop = ALU_BGTZ; end
            OP_BLEZ:  begin dec.cls = C_BRANCH; dec.aluop = ALU_BLEZ; end
            // REGIMM only defines bltz/bgez; other rt values fall through as illegal
            OP_REGIMM: begin
                if (rt == RT_BLTZ) begin dec.cls = C_BRANCH; dec.aluop = ALU_BLTZ; end
                else if (rt == RT_BGEZ) begin dec.cls = C_BRANCH; dec.aluop = ALU_BGEZ; end
            end
            OP_J:     dec.cls = C_JUMP;
            OP_JAL:   begin dec.cls = C_JUMP; dec.link = 1'b1; end
            default:  ;
        endcase
        case (op)
            OP_LH, OP_LHU, OP_SH: dec.lsop = LS_HALF;
            OP_LW, OP_SW:         dec.lsop = LS_WORD;
            default:              dec.lsop = LS_BYTE;
        endcase
        dec.dmext = (op == OP_LBU || op == OP_LHU);
    end
endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// MCPU multicycle controller: Moore FSM sequencing datapath enables, with
// ready-stretched memory states and decode on IR fields latched out of FETCH.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter bit MEM_HS  = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mcpu_ctrl_fsm_if.master bus
);
    state_e     state, nxt, st_o;
    logic [5:0] op_q, funct_q;
    logic [4:0] rt_q;
    logic       mem_done;
    logic [3:0] aluop;
    dec_t       dec;

    assign mem_done = !MEM_HS || bus.mem_ready;

    mcpu_ctrl_decode u_decode (.op(op_q), .funct(funct_q), .rt(rt_q), .dec(dec));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
            rt_q    <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH && mem_done) begin
                op_q    <= bus.op;
                funct_q <= bus.funct;
                rt_q    <= bus.rt;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: if (mem_done) nxt = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    C_R:             nxt = S_EXEC_R;
                    C_JR:            nxt = S_JR;
                    C_I:             nxt = S_EXEC_I;
                    C_LOAD, C_STORE: nxt = S_MEM_ADDR;
                    C_BRANCH:        nxt = S_BRANCH;
                    C_JUMP:          nxt = S_JUMP;
                    default:         nxt = S_FETCH;
                endcase
            end
            S_EXEC_R:   nxt = S_WB_R;
            S_EXEC_I:   nxt = S_WB_I;
            S_MEM_ADDR: nxt = (dec.cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_done) nxt = S_MEM_WB;
            S_MEM_WR:   if (mem_done) nxt = S_FETCH;
            default:    nxt = S_FETCH;
        endcase
    end

    // While reset is held the outputs look like a FETCH that never completes,
    // so no write strobe can escape whatever state the register holds.
    assign st_o = rst_n ? state : S_FETCH;

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.extop       = 1'b0;
        bus.dmEXTop     = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.PCSource    = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.RegDst      = 2'b00;
        bus.lsop        = 2'b00;
        bus.illegal     = 1'b0;
        aluop           = ALU_ADD;
        case (st_o)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = rst_n && mem_done;
                bus.PCWrite = rst_n && mem_done;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.illegal = (dec.cls == C_ILL);
            end
            S_EXEC_R, S_WB_R: begin
                bus.ALUSrcA  = 2'b10;
                bus.RegDst   = 2'b01;
                bus.RegWrite = (st_o == S_WB_R);
                aluop        = ALU_FUNCT;
            end
            S_JR: begin
                bus.ALUSrcA  = 2'b10;
                bus.PCWrite  = 1'b1;
                bus.RegWrite = dec.link;
                bus.RegDst   = dec.link ? 2'b01 : 2'b00;
                bus.MemtoReg = dec.link ? 2'b10 : 2'b00;
                aluop        = ALU_FUNCT;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.extop   = dec.extop;
                aluop       = dec.aluop;
            end
            S_WB_I: bus.RegWrite = 1'b1;
            S_MEM_ADDR: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
            end
            S_MEM_RD, S_MEM_WR: begin
                bus.IorD     = 1'b1;
                bus.mem_req  = 1'b1;
                bus.MemWrite = (st_o == S_MEM_WR);
                bus.lsop     = dec.lsop;
                bus.dmEXTop  = dec.dmext;
            end
            S_MEM_WB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = 1'b1;
                bus.lsop     = dec.lsop;
                bus.dmEXTop  = dec.dmext;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 2'b01;
                bus.PCSource    = 2'b01;
                bus.PCWriteCond = 1'b1;
                aluop           = dec.aluop;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                bus.RegWrite = dec.link;
                bus.RegDst   = dec.link ? 2'b10 : 2'b00;
                bus.MemtoReg = dec.link ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        bus.ALUOp   = ALUOP_W'(aluop);
        bus.state_o = st_o;
    end
endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized check of mcpu_ctrl_fsm against a per-instruction cycle-list model,
// on a handshaking 4-bit-ALUOp instance and a no-handshake 6-bit-ALUOp instance.
module tb_mcpu_ctrl_fsm;
    import mcpu_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [7:0] aluop;
        logic [1:0] memtoreg, pcsrc, srca, srcb, regdst, lsop;
        logic       mem_req, irw, pcw, pcwc, memw, regw, iord, extop, dmext, ill;
    } obs_t;

    typedef struct packed {
        int         cyc, irw, pcw, rw, mw, ill, ext, dm;
        obs_t       fin, rwo;
        logic [7:0] ext_alu;
    } stat_t;

    // State numbers follow the order the states are listed in the design description
    localparam int F = 0, D = 1, ER = 2, WR = 3, JRS = 4, EI = 5, WI = 6, MA = 7;
    localparam int MR = 8, MWB = 9, MW = 10, BR = 11, JP = 12;
    localparam int CL_R = 0, CL_JR = 1, CL_I = 2, CL_LD = 3, CL_ST = 4, CL_BR = 5, CL_J = 6, CL_ILL = 7;
    localparam int NOPS = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_na, rst_nb;
    int   n_chk = 0, n_fail = 0;

    mcpu_ctrl_fsm_if #(.ALUOP_W(4)) ifa ();
    mcpu_ctrl_fsm_if #(.ALUOP_W(6)) ifb ();
    mcpu_ctrl_fsm #(.ALUOP_W(4), .MEM_HS(1'b1)) dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));
    mcpu_ctrl_fsm #(.ALUOP_W(6), .MEM_HS(1'b0)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

    logic [5:0] optab [NOPS] = '{6'h00, 6'h00, 6'h01, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                                 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h22};

    function automatic int classify(logic [5:0] op, logic [5:0] funct, logic [4:0] rt);
        case (op)
            6'h00:                             return (funct == 6'd8 || funct == 6'd9) ? CL_JR : CL_R;
            6'h01:                             return (rt < 5'd2) ? CL_BR : CL_ILL;
            6'h02, 6'h03:                      return CL_J;
            6'h04, 6'h05, 6'h06, 6'h07:        return CL_BR;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return CL_LD;
            6'h28, 6'h29, 6'h2B:               return CL_ST;
            default:                           return (op >= 6'h08 && op <= 6'h0F) ? CL_I : CL_ILL;
        endcase
    endfunction

    function automatic logic [7:0] icode(logic [5:0] op);
        case (op)
            6'h08:   return 8'(ALU_ADDI);
            6'h09:   return 8'(ALU_ADDIU);
            6'h0A:   return 8'(ALU_SLTI);
            6'h0B:   return 8'(ALU_SLTIU);
            6'h0C:   return 8'(ALU_ANDI);
            6'h0D:   return 8'(ALU_ORI);
            6'h0E:   return 8'(ALU_XORI);
            default: return 8'(ALU_LUI);
        endcase
    endfunction

    function automatic logic [7:0] bcode(logic [5:0] op, logic [4:0] rt);
        case (op)
            6'h04:   return 8'h01;
            6'h05:   return 8'h0B;
            6'h07:   return 8'h0C;
            6'h06:   return 8'h0D;
            default: return (rt == 5'd0) ? 8'h0E : 8'h0F;
        endcase
    endfunction

    function automatic logic [1:0] lsz(logic [5:0] op);
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 2'd0;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2'd1;
        return 2'd2;
    endfunction

    function automatic obs_t expect_out(int st, bit done, logic [5:0] op, logic [5:0] funct, logic [4:0] rt);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            F:   begin e.mem_req = 1; e.srcb = 2'b01; e.irw = done; e.pcw = done; end
            D:   begin e.srcb = 2'b11; e.ill = (classify(op, funct, rt) == CL_ILL); end
            ER, WR: begin e.srca = 2'b10; e.aluop = 8'h02; e.regdst = 2'b01; e.regw = (st == WR); end
            JRS: begin
                e.srca = 2'b10; e.aluop = 8'h02; e.pcw = 1;
                if (funct == 6'd9) begin e.regw = 1; e.regdst = 2'b01; e.memtoreg = 2'b10; end
            end
            EI:  begin e.srca = 2'b01; e.srcb = 2'b10; e.aluop = icode(op); e.extop = (op == 6'h09); end
            WI:  e.regw = 1;
            MA:  begin e.srca = 2'b01; e.srcb = 2'b10; end
            MR, MW, MWB: begin
                e.lsop  = lsz(op);
                e.dmext = (op == 6'h24 || op == 6'h25);
                e.iord  = (st != MWB);
                e.mem_req = (st != MWB);
                e.memw  = (st == MW);
                if (st == MWB) begin e.memtoreg = 2'b01; e.regw = 1; end
            end
            BR:  begin e.srca = 2'b01; e.pcsrc = 2'b01; e.pcwc = 1; e.aluop = bcode(op, rt); end
            JP:  begin
                e.pcsrc = 2'b10; e.pcw = 1;
                if (op == 6'h03) begin e.regw = 1; e.regdst = 2'b10; e.memtoreg = 2'b10; end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t sample(int which);
        if (which == 0)
            return {ifa.state_o, 8'(ifa.ALUOp), ifa.MemtoReg, ifa.PCSource, ifa.ALUSrcA, ifa.ALUSrcB, ifa.RegDst,
                    ifa.lsop, ifa.mem_req, ifa.IRWrite, ifa.PCWrite, ifa.PCWriteCond, ifa.MemWrite,
                    ifa.RegWrite, ifa.IorD, ifa.extop, ifa.dmEXTop, ifa.illegal};
        return {ifb.state_o, 8'(ifb.ALUOp), ifb.MemtoReg, ifb.PCSource, ifb.ALUSrcA, ifb.ALUSrcB, ifb.RegDst,
                ifb.lsop, ifb.mem_req, ifb.IRWrite, ifb.PCWrite, ifb.PCWriteCond, ifb.MemWrite,
                ifb.RegWrite, ifb.IorD, ifb.extop, ifb.dmEXTop, ifb.illegal};
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic rst, input logic [5:0] op, input logic [5:0] funct,
                         input logic [4:0] rt, input logic rdy);
        if (which == 0) begin
            rst_na = rst; ifa.op = op; ifa.funct = funct; ifa.rt = rt; ifa.mem_ready = rdy;
        end else begin
            rst_nb = rst; ifb.op = op; ifb.funct = funct; ifb.rt = rt; ifb.mem_ready = rdy;
        end
    endtask

    // Called at a falling edge with the DUT in FETCH; returns at a falling edge.
    // Steps carrying bit 5 are wait cycles (mem_ready low).
    task automatic run(input int which, input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rt,
                       input int wf_in, input int wm_in, input int rst_at, input string tag, output stat_t s);
        int   seq[$];
        int   cl, st, wf, wm;
        bit   hs, d, memst;
        logic rdy;
        obs_t o;
        s  = '0;
        hs = (which == 0);
        wf = hs ? wf_in : 0;
        wm = hs ? wm_in : 0;
        cl = classify(op, funct, rt);
        repeat (wf) seq.push_back(F | 32);
        seq.push_back(F);
        seq.push_back(D);
        case (cl)
            CL_R:  begin seq.push_back(ER); seq.push_back(WR); end
            CL_JR: seq.push_back(JRS);
            CL_I:  begin seq.push_back(EI); seq.push_back(WI); end
            CL_LD, CL_ST: begin
                seq.push_back(MA);
                repeat (wm) seq.push_back(((cl == CL_LD) ? MR : MW) | 32);
                seq.push_back((cl == CL_LD) ? MR : MW);
                if (cl == CL_LD) seq.push_back(MWB);
            end
            CL_BR: seq.push_back(BR);
            CL_J:  seq.push_back(JP);
            default: ;
        endcase
        foreach (seq[i]) begin
            st = seq[i] & 31;
            d  = ((seq[i] & 32) == 0);
            if (i == rst_at) begin
                drive(which, 1'b0, 6'($urandom), 6'($urandom), 5'($urandom), 1'b0);
                #2;
                chk($sformatf("%s_in_reset", tag), sample(which), expect_out(F, 0, op, funct, rt));
                @(negedge clk);
                if (which == 0) rst_na = 1'b1; else rst_nb = 1'b1;
                return;
            end
            memst = (st == F || st == MR || st == MW);
            rdy   = !hs ? 1'b0 : (memst ? d : 1'($urandom));
            if (st == F) drive(which, 1'b1, op, funct, rt, rdy);
            else         drive(which, 1'b1, 6'($urandom), 6'($urandom), 5'($urandom), rdy);
            #2;
            o = sample(which);
            chk($sformatf("%s_step%0d", tag, i), o, expect_out(st, d, op, funct, rt));
            s.cyc++;
            s.irw += int'(o.irw); s.pcw += int'(o.pcw); s.rw  += int'(o.regw); s.mw += int'(o.memw);
            s.ill += int'(o.ill); s.ext += int'(o.extop); s.dm += int'(o.dmext);
            if (o.regw)  s.rwo = o;
            if (o.extop) s.ext_alu = o.aluop;
            s.fin = o;
            @(negedge clk);
        end
    endtask

    initial begin
        stat_t s;
        obs_t  o;
        drive(0, 1'b0, 6'h00, 6'h00, 5'h0, 1'b1);
        drive(1, 1'b0, 6'h00, 6'h00, 5'h0, 1'b1);
        // Reset held with mem_ready high: FETCH selects, no strobes
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("reset_a", sample(0), expect_out(F, 0, 6'h0, 6'h0, 5'h0));
            chk("reset_b", sample(1), expect_out(F, 0, 6'h0, 6'h0, 5'h0));
            @(negedge clk);
        end
        rst_na = 1'b1;

        run(0, OP_LW, 6'h0, 5'h0, 2, 3, -1, "lw_waits", s);
        chk("lw_cycles", 64'(s.cyc), 64'd10);
        chk("lw_irwrite", 64'(s.irw), 64'd1);
        chk("lw_pcwrite", 64'(s.pcw), 64'd1);
        chk("lw_regwrite", 64'(s.rw), 64'd1);
        chk("lw_memtoreg", 64'(s.rwo.memtoreg), 64'd1);
        chk("lw_lsop", 64'(s.rwo.lsop), 64'd2);

        run(0, 6'h01, 6'h0, 5'd0, 0, 0, -1, "bltz", s);
        chk("bltz_aluop", 64'(s.fin.aluop), 64'h0E);
        chk("bltz_cycles", 64'(s.cyc), 64'd3);
        run(0, 6'h01, 6'h0, 5'd1, 1, 0, -1, "bgez", s);
        chk("bgez_aluop", 64'(s.fin.aluop), 64'h0F);
        run(0, 6'h01, 6'h0, 5'd2, 0, 0, -1, "regimm_ill", s);
        chk("regimm_ill_cycles", 64'(s.cyc), 64'd2);
        chk("regimm_ill_pulses", 64'(s.ill), 64'd1);

        run(0, 6'h00, 6'd9, 5'h0, 0, 0, -1, "jalr", s);
        chk("jalr_cycles", 64'(s.cyc), 64'd3);
        chk("jalr_final", {s.fin.pcw, s.fin.regw, s.fin.regdst, s.fin.memtoreg}, 64'b11_01_10);
        run(0, 6'h03, 6'h0, 5'h0, 0, 0, -1, "jal", s);
        chk("jal_regdst", 64'(s.fin.regdst), 64'd2);

        // Reset lands while MEM_WR is stalled on mem_ready
        run(0, OP_SW, 6'h0, 5'h0, 0, 3, 4, "sw_rst", s);
        #1;
        o = sample(0);
        chk("post_reset_state", 64'(o.st), 64'd0);
        chk("post_reset_strobes", {o.memw, o.regw, o.irw, o.pcw}, 64'd0);

        for (int k = 0; k < 80; k++) begin
            logic [5:0] rop, rfn;
            logic [4:0] rrt;
            rop = optab[$urandom_range(NOPS - 1, 0)];
            rfn = ($urandom_range(1, 0) == 1) ? 6'(8 + $urandom_range(1, 0)) : 6'($urandom);
            rrt = 5'($urandom_range(3, 0));
            run(0, rop, rfn, rrt, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), -1, "rand_a", s);
        end

        rst_nb = 1'b1;
        run(1, OP_LBU, 6'h0, 5'h0, 0, 0, -1, "lbu_nohs", s);
        chk("lbu_cycles", 64'(s.cyc), 64'd5);
        chk("lbu_dmext_cycles", 64'(s.dm), 64'd2);
        chk("lbu_final_dmext", 64'(s.fin.dmext), 64'd1);
        run(1, OP_SH, 6'h0, 5'h0, 0, 0, -1, "sh_nohs", s);
        chk("sh_cycles", 64'(s.cyc), 64'd4);
        chk("sh_memwrite", 64'(s.mw), 64'd1);
        chk("sh_lsop", 64'(s.fin.lsop), 64'd1);
        run(1, OP_ADDIU, 6'h0, 5'h0, 0, 0, -1, "addiu_w6", s);
        chk("addiu_cycles", 64'(s.cyc), 64'd4);
        chk("addiu_extop_cycles", 64'(s.ext), 64'd1);
        chk("addiu_aluop", 64'(s.ext_alu), 64'(ALU_ADDIU));
        run(1, 6'h3F, 6'h0, 5'h0, 0, 0, -1, "op3f", s);
        chk("op3f_cycles", 64'(s.cyc), 64'd2);
        chk("op3f_pulses", 64'(s.ill), 64'd1);

        for (int k = 0; k < 40; k++) begin
            logic [5:0] rop, rfn;
            rop = optab[$urandom_range(NOPS - 1, 0)];
            rfn = ($urandom_range(1, 0) == 1) ? 6'(8 + $urandom_range(1, 0)) : 6'($urandom);
            run(1, rop, rfn, 5'($urandom_range(3, 0)), 0, 0, -1, "rand_b", s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
